thor2021_branch_resolve: RTL and testbench

- Branch-resolution stage directly downstream of the branch evaluator.
- Consumes the evaluator's taken flag with the instruction's PC, target and fetch-time prediction; detects mispredictions.
- On a mispredict, issues a held redirect to fetch, then squashes wrong-path instructions for a fixed drain window.
- Emits one predictor-update record per resolved branch and keeps branch/mispredict performance counters.

---
 rtl/thor2021_pkg.sv | 26 ++
 rtl/thor2021_perf_cnt.sv | 27 ++
 rtl/thor2021_branch_resolve.sv | 136 +++++++++++++
 tb/tb_thor2021_branch_resolve.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thor2021_pkg.sv
// -----------------------------------------------------------------------------
// thor2021_pkg
// Shared types for the Thor2021 branch-resolution and branch-predictor blocks.
//   brres_state_t : branch-resolve control states
//   addr_t        : default-width instruction address
//   bpu_update_t  : predictor update record {pc, tkn}
// -----------------------------------------------------------------------------
package thor2021_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DCNT_W = 4;   // drain window counter width (1..15)

   typedef enum logic [1:0] {
      IDLE,
      REDIR,
      DRAIN
   } brres_state_t;

   typedef logic [ADDR_W-1:0] addr_t;

   typedef struct packed {
      addr_t pc;
      logic  tkn;
   } bpu_update_t;

endpackage

// File: rtl/thor2021_perf_cnt.sv
// -----------------------------------------------------------------------------
// thor2021_perf_cnt
// Free-running performance counter: increments by one when en_i is high,
// wraps silently at 2^W.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (clears count)
//   en_i   : count enable
//   cnt_o  : current count
// -----------------------------------------------------------------------------
module thor2021_perf_cnt #(
   parameter int unsigned W = 40
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_o <= '0;
      end else if (en_i) begin
         cnt_o <= cnt_o + 1'b1;
      end
   end

endmodule

// File: rtl/thor2021_branch_resolve.sv
// -----------------------------------------------------------------------------
// thor2021_branch_resolve
// Branch-resolution stage behind the branch evaluator. Compares the resolved
// next PC with the PC fetch followed; on a mispredict it raises a held
// redirect to fetch, then squashes wrong-path instructions for DRAIN cycles.
// Every resolved branch produces a one-cycle predictor update record.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   valid_i / ready_o        : instruction handshake
//   isbr_i                   : conditional branch (else pass-through)
//   takb_i, pc_i, tgt_i      : evaluator result, branch PC, taken target
//   ilen_i                   : instruction length (fall-through = pc + ilen)
//   pred_tkn_i, pred_pc_i    : fetch-time prediction / followed PC
//   redir_v_o, redir_pc_o,
//   redir_rdy_i              : redirect handshake towards fetch
//   squash_o                 : kill younger in-flight instructions
//   bpu_v_o, bpu_pc_o,
//   bpu_tkn_o                : predictor update strobe and record
//   nbr_o, nmis_o            : resolved-branch / mispredict counters
// -----------------------------------------------------------------------------
module thor2021_branch_resolve
   import thor2021_pkg::*;
#(
   parameter int unsigned AWID  = 32,
   parameter int unsigned DRAIN = 3,
   parameter int unsigned CNTW  = 40
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic            isbr_i,
   input  logic            takb_i,
   input  logic [AWID-1:0] pc_i,
   input  logic [AWID-1:0] tgt_i,
   input  logic [3:0]      ilen_i,
   input  logic            pred_tkn_i,
   input  logic [AWID-1:0] pred_pc_i,
   output logic            redir_v_o,
   output logic [AWID-1:0] redir_pc_o,
   input  logic            redir_rdy_i,
   output logic            squash_o,
   output logic            bpu_v_o,
   output logic [AWID-1:0] bpu_pc_o,
   output logic            bpu_tkn_o,
   output logic [CNTW-1:0] nbr_o,
   output logic [CNTW-1:0] nmis_o
);

   // The DRAIN parameter shadows the imported state literal, so the state is
   // always referenced with its package scope.
   brres_state_t      state_q, state_d;
   logic [DCNT_W-1:0] dcnt_q;
   logic [AWID-1:0]   fall;
   logic [AWID-1:0]   npc;
   logic              mis;
   logic              resolve;

   assign fall    = pc_i + AWID'(ilen_i);
   assign npc     = takb_i ? tgt_i : fall;
   assign mis     = (npc != pred_pc_i);
   // ready_o is 1 in IDLE, so a branch accept in IDLE is simply valid_i there.
   assign resolve = valid_i && isbr_i && (state_q == thor2021_pkg::IDLE);

   always_comb begin
      state_d   = state_q;
      ready_o   = 1'b1;
      redir_v_o = 1'b0;
      squash_o  = 1'b0;
      unique case (state_q)
         thor2021_pkg::IDLE: begin
            if (resolve && mis) state_d = thor2021_pkg::REDIR;
         end
         thor2021_pkg::REDIR: begin
            ready_o   = 1'b0;
            redir_v_o = 1'b1;
            squash_o  = 1'b1;
            if (redir_rdy_i) state_d = thor2021_pkg::DRAIN;
         end
         thor2021_pkg::DRAIN: begin
            squash_o = 1'b1;
            if (dcnt_q == DCNT_W'(1)) state_d = thor2021_pkg::IDLE;
         end
         default: state_d = thor2021_pkg::IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= thor2021_pkg::IDLE;
         dcnt_q     <= '0;
         redir_pc_o <= '0;
         bpu_v_o    <= 1'b0;
         bpu_pc_o   <= '0;
         bpu_tkn_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         bpu_v_o <= resolve;
         if (resolve) begin
            bpu_pc_o  <= pc_i;
            bpu_tkn_o <= takb_i;
         end
         if (resolve && mis) begin
            redir_pc_o <= npc;
         end
         if ((state_q == thor2021_pkg::REDIR) && redir_rdy_i) begin
            dcnt_q <= DCNT_W'(DRAIN);
         end else if (state_q == thor2021_pkg::DRAIN) begin
            dcnt_q <= dcnt_q - 1'b1;
         end
      end
   end

   thor2021_perf_cnt #(.W(CNTW)) u_nbr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (resolve),
      .cnt_o  (nbr_o)
   );

   thor2021_perf_cnt #(.W(CNTW)) u_nmis (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (resolve && mis),
      .cnt_o  (nmis_o)
   );

`ifndef SYNTHESIS
   // A direction error whose predicted PC agrees with the predicted direction
   // (and whose two candidate PCs differ) must be counted as a mispredict.
   a_dir_mis: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (resolve && (pred_tkn_i != takb_i) && (tgt_i != fall) &&
       (pred_pc_i == (pred_tkn_i ? tgt_i : fall)))
      |=> (nmis_o == $past(nmis_o) + 1'b1));
`endif

endmodule

// File: tb/tb_thor2021_branch_resolve.sv
module tb_thor2021_branch_resolve;

   localparam int AWID  = 32;
   localparam int DRAIN = 3;
   localparam int CNTW  = 40;

   logic            clk;
   logic            rst_ni;
   logic            valid_i;
   logic            ready_o;
   logic            isbr_i;
   logic            takb_i;
   logic [AWID-1:0] pc_i;
   logic [AWID-1:0] tgt_i;
   logic [3:0]      ilen_i;
   logic            pred_tkn_i;
   logic [AWID-1:0] pred_pc_i;
   logic            redir_v_o;
   logic [AWID-1:0] redir_pc_o;
   logic            redir_rdy_i;
   logic            squash_o;
   logic            bpu_v_o;
   logic [AWID-1:0] bpu_pc_o;
   logic            bpu_tkn_o;
   logic [CNTW-1:0] nbr_o;
   logic [CNTW-1:0] nmis_o;

   thor2021_branch_resolve #(.AWID(AWID), .DRAIN(DRAIN), .CNTW(CNTW)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .isbr_i      (isbr_i),
      .takb_i      (takb_i),
      .pc_i        (pc_i),
      .tgt_i       (tgt_i),
      .ilen_i      (ilen_i),
      .pred_tkn_i  (pred_tkn_i),
      .pred_pc_i   (pred_pc_i),
      .redir_v_o   (redir_v_o),
      .redir_pc_o  (redir_pc_o),
      .redir_rdy_i (redir_rdy_i),
      .squash_o    (squash_o),
      .bpu_v_o     (bpu_v_o),
      .bpu_pc_o    (bpu_pc_o),
      .bpu_tkn_o   (bpu_tkn_o),
      .nbr_o       (nbr_o),
      .nmis_o      (nmis_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // scoreboard: expected predictor updates {pc, tkn} and redirect targets
   logic [AWID:0]   bpu_q[$];
   logic [AWID-1:0] redir_q[$];
   longint unsigned m_nbr  = 0;
   longint unsigned m_nmis = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AWID-1:0] next_pc(input logic [AWID-1:0] pc, input logic [AWID-1:0] tgt,
                                               input logic [3:0] ilen, input logic takb);
      logic [AWID-1:0] fallthrough;
      fallthrough = pc + AWID'(ilen);
      return takb ? tgt : fallthrough;
   endfunction

   task automatic check_cnt(input string tag);
      check({tag, "_nbr"},  64'(nbr_o),  64'(m_nbr  & ((64'd1 << CNTW) - 1)));
      check({tag, "_nmis"}, 64'(nmis_o), 64'(m_nmis & ((64'd1 << CNTW) - 1)));
   endtask

   // wrong-path stimulus offered while the stage is redirecting or draining
   task automatic drive_garbage();
      valid_i    = 1'b1;
      isbr_i     = 1'b1;
      pc_i       = $urandom;
      tgt_i      = $urandom;
      ilen_i     = 4'($urandom_range(0, 15));
      takb_i     = 1'($urandom_range(0, 1));
      pred_tkn_i = 1'($urandom_range(0, 1));
      pred_pc_i  = $urandom;
   endtask

   task automatic redirect_seq(input int hold);
      for (int j = 0; j <= hold; j++) begin
         redir_rdy_i = (j == hold);
         drive_garbage();
         @(negedge clk);
         check("redir_v_held", 64'(redir_v_o), 64'd1);
         check("squash_redir", 64'(squash_o), 64'd1);
         check("ready_redir",  64'(ready_o),  64'd0);
         @(posedge clk); #1;
      end
      for (int d = 0; d < DRAIN; d++) begin
         redir_rdy_i = 1'($urandom_range(0, 1));
         drive_garbage();
         @(negedge clk);
         check("squash_drain",  64'(squash_o),  64'd1);
         check("ready_drain",   64'(ready_o),   64'd1);
         check("redir_v_drain", 64'(redir_v_o), 64'd0);
         @(posedge clk); #1;
      end
      valid_i     = 1'b0;
      redir_rdy_i = 1'b0;
      @(negedge clk);
      check("squash_end",  64'(squash_o),  64'd0);
      check("redir_v_end", 64'(redir_v_o), 64'd0);
      @(posedge clk); #1;
   endtask

   // Called at posedge+1 with the stage idle; returns at posedge+1.
   task automatic drive_br(input logic [AWID-1:0] pc, input logic [AWID-1:0] tgt, input logic [3:0] ilen,
                           input logic takb, input logic ptkn, input logic [AWID-1:0] ppc,
                           input logic isbr, input int hold, input logic early);
      logic [AWID-1:0] npc;
      logic            mis;
      valid_i     = 1'b1;
      isbr_i      = isbr;
      pc_i        = pc;
      tgt_i       = tgt;
      ilen_i      = ilen;
      takb_i      = takb;
      pred_tkn_i  = ptkn;
      pred_pc_i   = ppc;
      redir_rdy_i = early;
      @(negedge clk);
      check("ready_idle", 64'(ready_o), 64'd1);
      @(posedge clk); #1;
      npc = next_pc(pc, tgt, ilen, takb);
      mis = isbr && (npc != ppc);
      if (isbr) begin
         bpu_q.push_back({pc, takb});
         m_nbr++;
         if (mis) begin
            m_nmis++;
            redir_q.push_back(npc);
         end
      end
      valid_i     = 1'b0;
      redir_rdy_i = 1'b0;
      if (mis) redirect_seq(hold);
   endtask

   // monitor: pops the scoreboard whenever the DUT presents an output
   initial begin
      logic            prev_rv;
      logic [AWID:0]   eb;
      logic [AWID-1:0] cur_rpc;
      prev_rv = 1'b0;
      cur_rpc = '0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            prev_rv = 1'b0;
         end else begin
            if (bpu_v_o) begin
               if (bpu_q.size() == 0) begin
                  check("bpu_unexpected", 64'd1, 64'd0);
               end else begin
                  eb = bpu_q.pop_front();
                  check("bpu_pc",  64'(bpu_pc_o),  64'(eb[AWID:1]));
                  check("bpu_tkn", 64'(bpu_tkn_o), 64'(eb[0]));
               end
            end
            if (redir_v_o) begin
               if (!prev_rv) begin
                  if (redir_q.size() == 0) begin
                     check("redir_unexpected", 64'd1, 64'd0);
                  end else begin
                     cur_rpc = redir_q.pop_front();
                  end
               end
               check("redir_pc", 64'(redir_pc_o), 64'(cur_rpc));
            end
            prev_rv = redir_v_o;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AWID-1:0] r_pc, r_tgt, r_npc, r_ppc;
      logic [3:0]      r_ilen;
      logic            r_takb;

      rst_ni      = 1'b0;
      valid_i     = 1'b0;
      isbr_i      = 1'b0;
      takb_i      = 1'b0;
      pc_i        = '0;
      tgt_i       = '0;
      ilen_i      = '0;
      pred_tkn_i  = 1'b0;
      pred_pc_i   = '0;
      redir_rdy_i = 1'b0;
      #22;
      check("rst_ready",    64'(ready_o),    64'd1);
      check("rst_redir_v",  64'(redir_v_o),  64'd0);
      check("rst_redir_pc", 64'(redir_pc_o), 64'd0);
      check("rst_squash",   64'(squash_o),   64'd0);
      check("rst_bpu_v",    64'(bpu_v_o),    64'd0);
      check("rst_nbr",      64'(nbr_o),      64'd0);
      check("rst_nmis",     64'(nmis_o),     64'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk); #1;

      // correct taken: no redirect, update next cycle
      drive_br(32'h1000, 32'h2000, 4'd4, 1'b1, 1'b1, 32'h2000, 1'b1, 0, 1'b0);
      @(negedge clk);
      check("ok_taken_squash", 64'(squash_o), 64'd0);
      check_cnt("ok_taken");
      @(posedge clk); #1;

      // direction mispredict, redirect held 5 cycles before fetch accepts
      drive_br(32'h1000, 32'h2000, 4'd4, 1'b0, 1'b1, 32'h2000, 1'b1, 5, 1'b0);
      check_cnt("dir_mis");

      // target mispredict; fetch ready already in the accept cycle
      drive_br(32'h1000, 32'h3000, 4'd4, 1'b1, 1'b1, 32'h2000, 1'b1, 0, 1'b1);
      check_cnt("tgt_mis");

      // fall-through wraps around the address space
      drive_br(32'hFFFF_FFFE, 32'h0000_0100, 4'd4, 1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
      check_cnt("wrap");

      // non-branch with mismatching PCs is a pass-through
      drive_br(32'h4000, 32'h5000, 4'd2, 1'b1, 1'b0, 32'h9999, 1'b0, 0, 1'b0);
      check_cnt("nonbr");

      // back-to-back correct branches, one per cycle
      for (int i = 0; i < 6; i++) begin
         r_pc   = 32'h8000 + 32'(i * 16);
         r_ilen = 4'd4;
         r_takb = i[0];
         r_tgt  = r_pc + 32'h400;
         r_npc  = next_pc(r_pc, r_tgt, r_ilen, r_takb);
         drive_br(r_pc, r_tgt, r_ilen, r_takb, r_takb, r_npc, 1'b1, 0, 1'b0);
      end
      check_cnt("b2b");

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         r_pc   = $urandom;
         r_tgt  = $urandom;
         r_ilen = 4'($urandom_range(0, 15));
         r_takb = 1'($urandom_range(0, 1));
         r_npc  = next_pc(r_pc, r_tgt, r_ilen, r_takb);
         r_ppc  = ($urandom_range(0, 2) == 0) ? $urandom : r_npc;
         drive_br(r_pc, r_tgt, r_ilen, r_takb, 1'($urandom_range(0, 1)), r_ppc,
                  1'($urandom_range(0, 9) != 0), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end
      check_cnt("random");

      // reset in the middle of a held redirect
      valid_i     = 1'b1;
      isbr_i      = 1'b1;
      pc_i        = 32'h7000;
      tgt_i       = 32'h7100;
      ilen_i      = 4'd4;
      takb_i      = 1'b1;
      pred_tkn_i  = 1'b0;
      pred_pc_i   = 32'h7004;
      redir_rdy_i = 1'b0;
      @(posedge clk); #1;
      bpu_q.push_back({32'h7000, 1'b1});
      redir_q.push_back(32'h7100);
      m_nbr++;
      m_nmis++;
      valid_i = 1'b0;
      @(posedge clk); #3;
      check("pre_rst_redir_v", 64'(redir_v_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      m_nbr  = 0;
      m_nmis = 0;
      check("midrst_redir_v", 64'(redir_v_o), 64'd0);
      check("midrst_squash",  64'(squash_o),  64'd0);
      check("midrst_ready",   64'(ready_o),   64'd1);
      check("midrst_bpu_v",   64'(bpu_v_o),   64'd0);
      check_cnt("midrst");
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("postrst_redir_v", 64'(redir_v_o), 64'd0);
      check("postrst_squash",  64'(squash_o),  64'd0);
      @(posedge clk); #1;

      // redirect still works after reset
      drive_br(32'h0000_0010, 32'h0000_0080, 4'd2, 1'b1, 1'b0, 32'h0000_0012, 1'b1, 2, 1'b0);
      check_cnt("postrst");

      @(negedge clk);
      check("bpu_q_drained",   64'(bpu_q.size()),   64'd0);
      check("redir_q_drained", 64'(redir_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
